// File: rtl/fpro_mailbox_pkg.sv
// Shared register offsets and bit positions for the FPro mailbox slot.
package fpro_mailbox_pkg;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_STAT = 3'd1;
    localparam logic [2:0] REG_POP  = 3'd2;
    localparam logic [2:0] REG_CTRL = 3'd3;
    localparam logic [2:0] REG_ERR  = 3'd4;

    localparam int STAT_RX_EMPTY   = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_RX_CNT_LSB = 8;
    localparam int STAT_TX_CNT_LSB = 16;

    localparam int ERR_TX_OVF = 0;
    localparam int ERR_RX_OVF = 1;
    localparam int ERR_RX_UDF = 2;
    localparam int ERR_W      = 3;

    localparam int CTRL_CLR_TX  = 0;
    localparam int CTRL_CLR_RX  = 1;
    localparam int CTRL_THR_LSB = 8;

endpackage

// File: rtl/fpro_mailbox_core_fifo.sv
// Synchronous first-word-fall-through FIFO used for both mailbox directions.
module mbox_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_wr, do_rd;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign count  = count_q;
    assign r_data = mem_q[rd_ptr_q];

    always_comb begin
        // A pop on a full FIFO frees the slot the simultaneous push lands in.
        do_wr    = wr && (!full || rd);
        do_rd    = rd && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + ADDR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + ADDR_W'(do_rd);
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (do_wr) begin
            mem_d[wr_ptr_q] = w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpro_mailbox_core.sv
// FPro MMIO slot: CPU <-> fabric mailbox with TX/RX FIFOs, sticky errors and threshold irq.
module fpro_mailbox_core
    import fpro_mailbox_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    input  logic [4:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    input  logic              hw_tx_rd,
    output logic [DATA_W-1:0] hw_tx_data,
    output logic              hw_tx_empty,
    input  logic              hw_rx_wr,
    input  logic [DATA_W-1:0] hw_rx_data,
    output logic              hw_rx_full,
    output logic              irq
);
    localparam int CNT_W = ADDR_W + 1;

    logic [2:0]        reg_sel;
    logic              cs_wr;
    logic              tx_push, rx_pop, clr_tx, clr_rx;
    logic              tx_full, rx_empty;
    logic [CNT_W-1:0]  tx_cnt, rx_cnt;
    logic [DATA_W-1:0] rx_head;
    logic [CNT_W-1:0]  thr_q, thr_d;
    logic [ERR_W-1:0]  err_q, err_d, err_set, err_w1c;
    logic              irq_q, irq_d;
    logic              unused_bus;

    assign reg_sel    = addr[2:0];
    assign cs_wr      = cs && write;
    assign unused_bus = ^{read, addr[4:3]};

    assign tx_push = cs_wr && (reg_sel == REG_DATA);
    assign rx_pop  = cs_wr && (reg_sel == REG_POP);
    assign clr_tx  = cs_wr && (reg_sel == REG_CTRL) && wr_data[CTRL_CLR_TX];
    assign clr_rx  = cs_wr && (reg_sel == REG_CTRL) && wr_data[CTRL_CLR_RX];

    mbox_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_tx),
        .wr     (tx_push),
        .rd     (hw_tx_rd),
        .w_data (wr_data[DATA_W-1:0]),
        .r_data (hw_tx_data),
        .empty  (hw_tx_empty),
        .full   (tx_full),
        .count  (tx_cnt)
    );

    mbox_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_rx),
        .wr     (hw_rx_wr),
        .rd     (rx_pop),
        .w_data (hw_rx_data),
        .r_data (rx_head),
        .empty  (rx_empty),
        .full   (hw_rx_full),
        .count  (rx_cnt)
    );

    always_comb begin
        thr_d   = thr_q;
        err_set = '0;
        err_w1c = '0;
        if (cs_wr && (reg_sel == REG_CTRL)) begin
            thr_d = wr_data[CTRL_THR_LSB +: CNT_W];
        end
        if (cs_wr && (reg_sel == REG_ERR)) begin
            err_w1c = wr_data[ERR_W-1:0];
        end
        // A push that coincides with a pop on a full FIFO is not an overflow.
        err_set[ERR_TX_OVF] = tx_push && tx_full && !hw_tx_rd;
        err_set[ERR_RX_OVF] = hw_rx_wr && hw_rx_full && !rx_pop;
        err_set[ERR_RX_UDF] = rx_pop && rx_empty;
        err_d = (err_q & ~err_w1c) | err_set;
        irq_d = (rx_cnt >= thr_q) && (thr_q != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_q <= '0;
            err_q <= '0;
            irq_q <= 1'b0;
        end else begin
            thr_q <= thr_d;
            err_q <= err_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA: if (!rx_empty) rd_data[DATA_W-1:0] = rx_head;
            REG_STAT: begin
                rd_data[STAT_TX_CNT_LSB +: CNT_W] = tx_cnt;
                rd_data[STAT_RX_CNT_LSB +: CNT_W] = rx_cnt;
                rd_data[STAT_TX_FULL]             = tx_full;
                rd_data[STAT_RX_EMPTY]            = rx_empty;
            end
            REG_CTRL: rd_data[CTRL_THR_LSB +: CNT_W] = thr_q;
            REG_ERR:  rd_data[ERR_W-1:0] = err_q;
            default:  rd_data = '0;
        endcase
    end

endmodule
